ps2_flap_receiver: RTL and testbench
====================================

Name: ps2_flap_receiver

Overview:
- PS/2 keyboard receiver, device-to-host direction, for the Flappy Bird top level.
- Deserialises 11-bit PS/2 frames and checks framing and parity.
- Decodes make/break codes into held-key levels for the arrow keys and a single-cycle flap pulse for the space bar.
- Outputs feed the same game logic inputs as BtnU/BtnD/BtnL/BtnR, as an alternative controller.

Parameters:
- FILT_LEN, 8: consecutive identical ps2_clk samples required before the filtered clock level changes.
- TIMEOUT_CYC, 100000: ClkPort cycles without a falling edge before a partial frame is aborted (1 ms at 100 MHz).

Ports:
- ClkPort  input  1  system clock, 100 MHz
- Reset  input  1  asynchronous, active-high
- ps2_clk  input  1  PS/2 clock from keyboard, asynchronous
- ps2_data  input  1  PS/2 data from keyboard, asynchronous
- rx_byte  output  8  last correctly received byte
- rx_valid  output  1  one-cycle pulse when rx_byte updates
- rx_err  output  1  one-cycle pulse on a parity, stop or timeout error
- key_up  output  1  level, high while the E0 75 key is held
- key_down  output  1  level, high while the E0 72 key is held
- key_left  output  1  level, high while the E0 6B key is held
- key_right  output  1  level, high while the E0 74 key is held
- flap_pulse  output  1  one-cycle pulse on a space (0x29) make

Behaviour:
- Reset is asynchronous, active-high; clock is ClkPort.
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Prefix flags cleared.
  - Filtered clock set to 1.
  - Synchronisers set to 1.
- Synchronisation and filtering:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - The filtered clock toggles only after FILT_LEN consecutive synchronised samples differ from its current value.
  - A falling edge = filtered clock 1→0; it is a one-cycle internal strobe.
  - Data is sampled on that strobe from synchronised ps2_data.
- Frame FSM (advances on falling-edge strobes only):
  - IDLE: a sampled 0 (start bit) → DATA with bit count 0; a sampled 1 stays in IDLE with no error.
  - DATA: shift bits in LSB first; after the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: the frame is good if the stop bit = 1 and the XOR of the 8 data bits and the parity bit = 1 (odd parity).
    - Good frame: rx_byte is loaded and rx_valid pulses on the cycle after the stop-bit strobe.
    - Bad frame: rx_err pulses on that same cycle, rx_byte is unchanged, and the prefix flags are cleared.
    - Either way → IDLE.
- Timeout:
  - The counter runs while the FSM is not in IDLE and resets on every strobe.
  - When it reaches TIMEOUT_CYC → IDLE, rx_err pulses, prefix flags are cleared, no rx_valid.
- Decoder (acts on each rx_valid, in the same cycle it is seen, registered one cycle later):
  - 0xE0 sets the ext flag.
  - 0xF0 sets the brk flag.
  - Any other byte is a code: it is applied with the current flags, then both flags are cleared.
  - ext=1 with 75/72/6B/74: set the matching key_* level when brk=0, clear it when brk=1.
  - ext=0 with 29: brk=0 sets the internal space_held level; brk=1 clears it.
  - flap_pulse asserts for one cycle only on a space make while space_held was 0, so typematic repeats are suppressed.
  - Unknown codes: flags cleared, no output change.
  - ext=0 with an arrow code, or ext=1 with 29: ignored.
- Latency:
  - rx_valid: 1 cycle after the stop strobe.
  - key_* / flap_pulse: 1 cycle after rx_valid.
- Simultaneous events: a strobe always wins over timeout expiry in the same cycle, and the counter resets.
- Reset mid-frame: the partial frame is discarded, held keys are cleared, and no pulse is generated.
- Glitches on ps2_clk shorter than FILT_LEN cycles produce no strobe.

Test Plan:
- Reset, then send frame 0x29 (start 0, bits 1,0,0,1,0,1,0,0, parity 0, stop 1) → rx_byte=0x29, rx_valid one cycle, flap_pulse one cycle, rx_err=0.
- Send 0x29 three times, then F0 29, then 29 → exactly 2 flap_pulses (first make and post-break make); rx_valid 6 times.
- Send E0 75 → key_up=1; then E0 F0 75 → key_up=0; other key_* stay 0 throughout.
- Send 0x1C with the parity bit inverted → rx_err one cycle, rx_valid never asserts, rx_byte keeps its previous value; a following valid E0 6B → key_left=1.
- Send start + 4 data bits, then stop clocking for 100000 cycles → rx_err pulses at timeout, FSM idle; a next full frame 0x29 decodes correctly.
- Inject 3-cycle low glitches on ps2_clk during IDLE and DATA → no extra bits; then assert Reset mid-frame with key_right held → all outputs 0 immediately.

Source files
------------

// File: rtl/ps2_flap_receiver_if.sv
// ps2_flap_if: PS/2 line inputs and decoded receiver/controller outputs
interface ps2_flap_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       flap_pulse;
  modport master (
    output ps2_clk, ps2_data,
    input  rx_byte, rx_valid, rx_err, key_up, key_down, key_left, key_right, flap_pulse
  );
  modport slave (
    input  ps2_clk, ps2_data,
    output rx_byte, rx_valid, rx_err, key_up, key_down, key_left, key_right, flap_pulse
  );
endinterface

// File: rtl/ps2_flap_receiver.sv
// ps2_flap_receiver: PS/2 frame receiver with arrow-key levels and space-bar flap pulse
module ps2_flap_receiver #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input logic         ClkPort,
  input logic         Reset,
  ps2_flap_if.slave   bus
);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic clk_s1, clk_s2, dat_s1, dat_s2, clk_f, fall, filt_hit;
  logic [FW-1:0] fcnt;
  logic [7:0] sh, sh_n, rx_byte_q;
  logic [2:0] bcnt, bcnt_n;
  logic par, par_n, valid_n, err_n, rx_valid_q, rx_err_q;
  logic [TW-1:0] tcnt, tcnt_n;
  logic ext, brk, space_held, up_q, down_q, left_q, right_q, flap_q;
  assign filt_hit = (clk_s2 != clk_f) && (fcnt == FW'(FILT_LEN - 1));
  always_ff @(posedge ClkPort or posedge Reset)
    if (Reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      clk_f  <= 1'b1;
      fcnt   <= '0;
      fall   <= 1'b0;
    end else begin
      {clk_s2, clk_s1} <= {clk_s1, bus.ps2_clk};
      {dat_s2, dat_s1} <= {dat_s1, bus.ps2_data};
      fcnt  <= (clk_s2 != clk_f && !filt_hit) ? fcnt + 1'b1 : '0;
      clk_f <= filt_hit ? ~clk_f : clk_f;
      fall  <= filt_hit & clk_f;
    end
  always_comb begin
    state_n = state;
    sh_n    = sh;
    bcnt_n  = bcnt;
    par_n   = par;
    tcnt_n  = '0;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (fall)
      unique case (state)
        IDLE: begin
          state_n = dat_s2 ? IDLE : DATA;
          bcnt_n  = '0;
        end
        DATA: begin
          sh_n    = {dat_s2, sh[7:1]};
          bcnt_n  = bcnt + 3'd1;
          state_n = (bcnt == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_n   = dat_s2;
          state_n = STOP;
        end
        STOP: begin
          valid_n = dat_s2 & (^{sh, par});
          err_n   = ~valid_n;
          state_n = IDLE;
        end
      endcase
    else if (state != IDLE) begin
      tcnt_n = tcnt + 1'b1;
      if (tcnt_n == TW'(TIMEOUT_CYC)) begin
        state_n = IDLE;
        err_n   = 1'b1;
        tcnt_n  = '0;
      end
    end
  end
  always_ff @(posedge ClkPort or posedge Reset)
    if (Reset) begin
      state      <= IDLE;
      sh         <= '0;
      bcnt       <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      bcnt       <= bcnt_n;
      par        <= par_n;
      tcnt       <= tcnt_n;
      rx_byte_q  <= valid_n ? sh : rx_byte_q;
      rx_valid_q <= valid_n;
      rx_err_q   <= err_n;
    end
  always_ff @(posedge ClkPort or posedge Reset)
    if (Reset) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      space_held <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      flap_q     <= 1'b0;
    end else begin
      flap_q <= 1'b0;
      if (rx_err_q) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (rx_valid_q) begin
        if (rx_byte_q == 8'hE0) ext <= 1'b1;
        else if (rx_byte_q == 8'hF0) brk <= 1'b1;
        else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (ext) begin
            if (rx_byte_q == 8'h75) up_q    <= ~brk;
            if (rx_byte_q == 8'h72) down_q  <= ~brk;
            if (rx_byte_q == 8'h6B) left_q  <= ~brk;
            if (rx_byte_q == 8'h74) right_q <= ~brk;
          end else if (rx_byte_q == 8'h29) begin
            space_held <= ~brk;
            flap_q     <= ~brk & ~space_held;
          end
        end
      end
    end
  assign bus.rx_byte    = rx_byte_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_err     = rx_err_q;
  assign bus.key_up     = up_q;
  assign bus.key_down   = down_q;
  assign bus.key_left   = left_q;
  assign bus.key_right  = right_q;
  assign bus.flap_pulse = flap_q;
endmodule

// File: tb/tb_ps2_flap_receiver.sv
// tb_ps2_flap_receiver: directed PS/2 frames checked against a byte-stream key model every cycle
module tb_ps2_flap_receiver;
  localparam int H  = 20;
  localparam int TO = 3000;
  typedef struct {bit err; logic [7:0] b;} ev_t;
  logic ClkPort = 1'b0;
  logic Reset   = 1'b1;
  always #5 ClkPort = ~ClkPort;
  ps2_flap_if bus();
  ps2_flap_receiver #(.FILT_LEN(8), .TIMEOUT_CYC(TO)) dut (
    .ClkPort(ClkPort),
    .Reset(Reset),
    .bus(bus)
  );
  int checks = 0, errors = 0;
  int valid_cnt = 0, flap_cnt = 0, err_cnt = 0;
  ev_t evq[$];
  bit ext_held[256];
  bit space_m, seen_e0, seen_f0, exp_flap, pend, prev_v, prev_e;
  logic [7:0] pend_b, last_good;
  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task model_decode(input logic [7:0] b);
    if (b == 8'hE0) seen_e0 = 1'b1;
    else if (b == 8'hF0) seen_f0 = 1'b1;
    else begin
      if (seen_e0 && (b == 8'h75 || b == 8'h72 || b == 8'h6B || b == 8'h74)) ext_held[b] = !seen_f0;
      if (!seen_e0 && b == 8'h29) begin
        exp_flap = !seen_f0 && !space_m;
        space_m  = !seen_f0;
      end
      seen_e0 = 1'b0;
      seen_f0 = 1'b0;
    end
  endtask
  always @(negedge ClkPort) begin
    if (Reset) begin
      check({bus.rx_byte, bus.rx_valid, bus.rx_err, bus.key_up, bus.key_down, bus.key_left, bus.key_right, bus.flap_pulse} == 15'd0,
            "reset_outputs", {bus.rx_byte, bus.rx_valid, bus.rx_err, bus.key_up, bus.key_down, bus.key_left, bus.key_right, bus.flap_pulse}, 0);
      foreach (ext_held[i]) ext_held[i] = 1'b0;
      {space_m, seen_e0, seen_f0, exp_flap, pend, prev_v, prev_e} = '0;
      last_good = 8'h00;
    end else begin
      ev_t e;
      exp_flap = 1'b0;
      if (pend) begin
        model_decode(pend_b);
        pend = 1'b0;
      end
      check({bus.key_up, bus.key_down, bus.key_left, bus.key_right, bus.flap_pulse} ==
            {ext_held[8'h75], ext_held[8'h72], ext_held[8'h6B], ext_held[8'h74], exp_flap},
            "keys_flap", {bus.key_up, bus.key_down, bus.key_left, bus.key_right, bus.flap_pulse},
            {ext_held[8'h75], ext_held[8'h72], ext_held[8'h6B], ext_held[8'h74], exp_flap});
      if (bus.flap_pulse) flap_cnt++;
      if (bus.rx_valid) begin
        valid_cnt++;
        check(!prev_v && !bus.rx_err, "valid_single_cycle", {prev_v, bus.rx_err}, 0);
        check(evq.size() > 0 && !evq[0].err, "valid_expected", evq.size(), 1);
        if (evq.size() > 0) begin
          e = evq.pop_front();
          check(bus.rx_byte == e.b, "rx_byte", bus.rx_byte, e.b);
          last_good = e.b;
          pend      = 1'b1;
          pend_b    = e.b;
        end
      end
      if (bus.rx_err) begin
        err_cnt++;
        check(!prev_e, "err_single_cycle", prev_e, 0);
        check(evq.size() > 0 && evq[0].err, "err_expected", evq.size(), 1);
        if (evq.size() > 0) e = evq.pop_front();
        seen_e0 = 1'b0;
        seen_f0 = 1'b0;
      end
      check(bus.rx_byte == last_good, "rx_byte_hold", bus.rx_byte, last_good);
      prev_v = bus.rx_valid;
      prev_e = bus.rx_err;
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge ClkPort);
  endtask
  task automatic ps2_bit(input logic v, input bit glitch);
    bus.ps2_data = v;
    cyc(H / 2);
    if (glitch) begin
      bus.ps2_clk = 1'b0;
      cyc(3);
      bus.ps2_clk = 1'b1;
    end
    cyc(H / 2);
    bus.ps2_clk = 1'b0;
    cyc(H);
    bus.ps2_clk = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] b, input bit bad, input int gbit);
    logic [10:0] f;
    ev_t e;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    e.err = bad;
    e.b   = b;
    evq.push_back(e);
    for (int i = 0; i < 11; i++) ps2_bit(f[i], i == gbit);
    cyc(100);
  endtask
  task automatic partial(input int n);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < n; i++) ps2_bit(i[0], 1'b0);
  endtask
  task automatic drain();
    for (int i = 0; i < 5000 && evq.size() != 0; i++) cyc(1);
    check(evq.size() == 0, "drain_timeout", evq.size(), 0);
    evq.delete();
    cyc(5);
  endtask
  task automatic do_reset();
    @(negedge ClkPort);
    #2 Reset = 1'b1;
    cyc(3);
    #2 Reset = 1'b0;
    cyc(5);
  endtask
  initial begin
    int v0, f0, e0;
    ev_t e;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    cyc(5);
    #2 Reset = 1'b0;
    cyc(5);
    send_frame(8'h29, 1'b0, -1);
    drain();
    check(bus.rx_byte == 8'h29, "t1_byte", bus.rx_byte, 8'h29);
    check(valid_cnt == 1, "t1_valid_cnt", valid_cnt, 1);
    check(flap_cnt == 1, "t1_flap_cnt", flap_cnt, 1);
    check(err_cnt == 0, "t1_err_cnt", err_cnt, 0);
    do_reset();
    v0 = valid_cnt;
    f0 = flap_cnt;
    send_frame(8'h29, 1'b0, -1);
    send_frame(8'h29, 1'b0, -1);
    send_frame(8'h29, 1'b0, -1);
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'h29, 1'b0, -1);
    send_frame(8'h29, 1'b0, -1);
    drain();
    check(flap_cnt - f0 == 2, "t2_flap_cnt", flap_cnt - f0, 2);
    check(valid_cnt - v0 == 6, "t2_valid_cnt", valid_cnt - v0, 6);
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'h75, 1'b0, -1);
    drain();
    check({bus.key_up, bus.key_down, bus.key_left, bus.key_right} == 4'b1000, "t3_up_set",
          {bus.key_up, bus.key_down, bus.key_left, bus.key_right}, 4'b1000);
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'h75, 1'b0, -1);
    drain();
    check({bus.key_up, bus.key_down, bus.key_left, bus.key_right} == 4'b0000, "t3_up_clr",
          {bus.key_up, bus.key_down, bus.key_left, bus.key_right}, 4'b0000);
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, -1);
    drain();
    check(err_cnt - e0 == 1, "t4_err_cnt", err_cnt - e0, 1);
    check(valid_cnt == v0, "t4_no_valid", valid_cnt - v0, 0);
    check(bus.rx_byte == 8'h75, "t4_byte_kept", bus.rx_byte, 8'h75);
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'h6B, 1'b0, -1);
    drain();
    check(bus.key_left == 1'b1, "t4_left", bus.key_left, 1);
    v0 = valid_cnt;
    e0 = err_cnt;
    e.err = 1'b1;
    e.b   = 8'h00;
    evq.push_back(e);
    partial(4);
    drain();
    check(err_cnt - e0 == 1, "t5_timeout_err", err_cnt - e0, 1);
    check(valid_cnt == v0, "t5_no_valid", valid_cnt - v0, 0);
    send_frame(8'h29, 1'b0, -1);
    drain();
    check(bus.rx_byte == 8'h29, "t5_byte_after", bus.rx_byte, 8'h29);
    v0 = valid_cnt;
    bus.ps2_clk = 1'b0;
    cyc(3);
    bus.ps2_clk = 1'b1;
    cyc(40);
    send_frame(8'hE0, 1'b0, 3);
    send_frame(8'h74, 1'b0, 5);
    drain();
    check(valid_cnt - v0 == 2, "t6_glitch_valid", valid_cnt - v0, 2);
    check(bus.key_right == 1'b1, "t6_right", bus.key_right, 1);
    check(bus.rx_byte == 8'h74, "t6_byte", bus.rx_byte, 8'h74);
    partial(3);
    @(negedge ClkPort);
    #2 Reset = 1'b1;
    #1 check({bus.rx_byte, bus.rx_valid, bus.rx_err, bus.key_up, bus.key_down, bus.key_left, bus.key_right, bus.flap_pulse} == 15'd0,
             "t6_async_reset", {bus.rx_byte, bus.rx_valid, bus.rx_err, bus.key_up, bus.key_down, bus.key_left, bus.key_right, bus.flap_pulse}, 0);
    cyc(3);
    #2 Reset = 1'b0;
    cyc(5);
    f0 = flap_cnt;
    send_frame(8'h29, 1'b0, -1);
    drain();
    check(flap_cnt - f0 == 1, "t6_flap_after_reset", flap_cnt - f0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
